// File: rtl/store_unit.sv
// Store unit: aligns store data onto byte lanes, raises address-error
// exceptions and runs the request/acknowledge handshake with the data bus.
module store_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   output logic        st_done,
   output logic        st_ades,
   output logic [31:0] bad_vaddr
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] REQ  = 2'b01;
   localparam logic [1:0] WAIT = 2'b10;

   logic [1:0]  state;
   logic        misalign;
   logic [1:0]  enc_size;
   logic [31:0] enc_wdata;
   logic [3:0]  enc_wstrb;

   assign st_ready = (state == IDLE);
   assign data_req = (state == REQ);
   assign data_wr  = 1'b1;

   assign misalign = (st_op == 2'b11)
                   | ((st_op == 2'b01) & st_addr[0])
                   | ((st_op == 2'b10) & (|st_addr[1:0]));

   always_comb begin
      enc_size  = 2'd2;
      enc_wdata = st_data;
      enc_wstrb = 4'b1111;
      case (st_op)
         2'b00: begin
            enc_size  = 2'd0;
            enc_wdata = {4{st_data[7:0]}};
            enc_wstrb = 4'b0001 << st_addr[1:0];
         end
         2'b01: begin
            enc_size  = 2'd1;
            enc_wdata = {2{st_data[15:0]}};
            enc_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            enc_size  = 2'd2;
            enc_wdata = st_data;
            enc_wstrb = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         st_done    <= 1'b0;
         st_ades    <= 1'b0;
         data_size  <= 2'd0;
         data_addr  <= 32'd0;
         data_wdata <= 32'd0;
         data_wstrb <= 4'd0;
         bad_vaddr  <= 32'd0;
      end else begin
         st_done <= 1'b0;
         st_ades <= 1'b0;
         case (state)
            IDLE: begin
               if (st_valid) begin
                  if (misalign) begin
                     st_ades   <= 1'b1;
                     bad_vaddr <= st_addr;
                  end else begin
                     data_size  <= enc_size;
                     data_addr  <= st_addr;
                     data_wdata <= enc_wdata;
                     data_wstrb <= enc_wstrb;
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               // data_ok alone cannot complete a write whose address was not taken
               if (data_addr_ok) begin
                  if (data_data_ok) begin
                     state   <= IDLE;
                     st_done <= 1'b1;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (data_data_ok) begin
                  state   <= IDLE;
                  st_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
